// File: rtl/psa_pkg.sv
// Shared types and elaboration helpers for prefix_sweep_adder.
// Optional subtract mode is enabled by defining PSA_SUB_EN.
package psa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    SUM  = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = i + 1;
    end
    return r;
  endfunction

  // True when tree node `node` is updated at level `lvl` of the up- or down-sweep.
  function automatic logic node_active(input int unsigned node, input int unsigned lvl,
                                       input logic down);
    int unsigned span;
    int unsigned half;
    span = 32'd1 << (lvl + 1);
    half = 32'd1 << lvl;
    if (!down) return ((node + 1) % span) == 0;
    return (((node + 1) % span) == half) && (node >= span);
  endfunction

endpackage

// File: rtl/prefix_sweep_adder_if.sv
// Start/done operand bus for prefix_sweep_adder; carries `sub` only when PSA_SUB_EN is defined.
interface prefix_sweep_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef PSA_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
`ifdef PSA_SUB_EN
        output sub,
`endif
        output start, a, b, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
`ifdef PSA_SUB_EN
        input  sub,
`endif
        input  start, a, b, c_in,
        output busy, done, sum, c_out
    );
endinterface

// File: rtl/gp_combine_cell.sv
// One generate/propagate combine node: (G,P) = hi o lo.
module gp_combine_cell (
    input  logic G_hi,
    input  logic P_hi,
    input  logic G_lo,
    input  logic P_lo,
    output logic G,
    output logic P
);
    assign G = G_hi | (P_hi & G_lo);
    assign P = P_hi & P_lo;
endmodule

// File: rtl/prefix_sweep_adder.sv
// Multi-cycle Brent-Kung adder: one row of combine cells swept up then down the tree.
// Defining PSA_SUB_EN adds a subtract request (b inverted, carry-in forced to 1).
module prefix_sweep_adder
    import psa_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    prefix_sweep_adder_if.slave bus
);
    localparam int unsigned LEVELS = clog2(WIDTH);
    localparam int unsigned LW     = clog2(LEVELS);
    localparam int unsigned NCAND  = 1 << LW;

    state_e           state_q, state_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic [WIDTH-1:0] g_q, g_d, pp_q, pp_d, p_q, p_d, sum_q, sum_d;
    logic             cin_q, cin_d, cout_q, cout_d, done_q, done_d;

    logic [WIDTH-1:0] en, g_c, p_c, g_lo, p_lo;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             sweeping, down;

`ifdef PSA_SUB_EN
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub | bus.c_in;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.c_in;
`endif

    assign sweeping = (state_q == UP) || (state_q == DOWN);
    assign down     = (state_q == DOWN);

    // Each cell picks its low operand at distance 2^lvl; taps below node 0 read as zero.
    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        logic [NCAND-1:0] g_cand, p_cand;
        for (genvar k = 0; k < NCAND; k++) begin : g_tap
            if (k < LEVELS && i >= (1 << k)) begin : g_src
                assign g_cand[k] = g_q[i-(1<<k)];
                assign p_cand[k] = pp_q[i-(1<<k)];
            end else begin : g_none
                assign g_cand[k] = 1'b0;
                assign p_cand[k] = 1'b0;
            end
        end
        assign g_lo[i] = g_cand[lvl_q];
        assign p_lo[i] = p_cand[lvl_q];
        assign en[i]   = sweeping && node_active(i, 32'(lvl_q), down);

        gp_combine_cell u_cell (
            .G_hi (g_q[i]),
            .P_hi (pp_q[i]),
            .G_lo (g_lo[i]),
            .P_lo (p_lo[i]),
            .G    (g_c[i]),
            .P    (p_c[i])
        );
    end

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        g_d     = g_q;
        pp_d    = pp_q;
        p_d     = p_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (en[i]) begin
                g_d[i]  = g_c[i];
                pp_d[i] = p_c[i];
            end
        end
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    p_d     = bus.a ^ b_eff;
                    pp_d    = p_d;
                    g_d     = bus.a & b_eff;
                    g_d[0]  = g_d[0] | (p_d[0] & cin_eff);
                    cin_d   = cin_eff;
                    lvl_d   = '0;
                    state_d = UP;
                end
            end
            UP: begin
                if (lvl_q == LW'(LEVELS - 1)) begin
                    state_d = DOWN;
                    lvl_d   = LW'(LEVELS - 2);
                end else begin
                    lvl_d = lvl_q + 1'b1;
                end
            end
            DOWN: begin
                if (lvl_q == '0) state_d = SUM;
                else             lvl_d   = lvl_q - 1'b1;
            end
            SUM: begin
                sum_d   = p_q ^ {g_q[WIDTH-2:0], cin_q};
                cout_d  = g_q[WIDTH-1];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lvl_q   <= '0;
            g_q     <= '0;
            pp_q    <= '0;
            p_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            g_q     <= g_d;
            pp_q    <= pp_d;
            p_q     <= p_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.c_out = cout_q;
endmodule

// File: tb/tb_prefix_sweep_adder.sv
// Directed and random checks of prefix_sweep_adder at WIDTH=16 (subtract cases under PSA_SUB_EN).
module tb_prefix_sweep_adder;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    prefix_sweep_adder_if #(.WIDTH(16)) bus ();

    prefix_sweep_adder #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input logic ts);
        bus.a = ta;
        bus.b = tb_;
`ifdef PSA_SUB_EN
        bus.c_in = tc;
        bus.sub  = ts;
`else
        bus.c_in = tc | ts;
`endif
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tc, input logic ts, input logic [15:0] es,
                          input logic ec);
        int cnt;
        drive(ta, tb_, tc, ts);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(cnt);
        check({tag, "_lat"}, 32'(cnt), 32'd8);
        check({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check({tag, "_cout"}, 32'(bus.c_out), 32'(ec));
    endtask

    logic [15:0] ba[3], bb[3], bs[3];
    logic        bc[3], bco[3];

    initial begin
        int cnt;
        int ndone;
        logic [15:0] ra, rb, es;
        logic        rc, rs, ec;
        logic [16:0] full;

        ba[0] = 16'h8000; bb[0] = 16'h8000; bc[0] = 1'b0; bs[0] = 16'h0000; bco[0] = 1'b1;
        ba[1] = 16'h7FFF; bb[1] = 16'h0001; bc[1] = 1'b0; bs[1] = 16'h8000; bco[1] = 1'b0;
        ba[2] = 16'h0F0F; bb[2] = 16'hF0F0; bc[2] = 1'b1; bs[2] = 16'h0000; bco[2] = 1'b1;

        rst = 1'b1;
        bus.start = 1'b0;
        drive(16'h0, 16'h0, 1'b0, 1'b0);
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.c_out), 32'd0);
        rst = 1'b0;
        tick();

        // Full carry ripple; busy/done timing checked cycle by cycle.
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            check("t1_busy_pre", 32'(bus.busy), 32'd1);
            check("t1_done_pre", 32'(bus.done), 32'd0);
            tick();
        end
        check("t1_done", 32'(bus.done), 32'd1);
        check("t1_busy_post", 32'(bus.busy), 32'd0);
        check("t1_sum", 32'(bus.sum), 32'h0000);
        check("t1_cout", 32'(bus.c_out), 32'd1);
        tick();
        check("t1_done_pulse", 32'(bus.done), 32'd0);
        check("t1_sum_hold", 32'(bus.sum), 32'h0000);

        run_op("t2", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);

        // Reset four edges into an operation.
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_sum", 32'(bus.sum), 32'd0);
        check("mid_rst_cout", 32'(bus.c_out), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        check("mid_rst_no_done", 32'(ndone), 32'd0);
        run_op("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0);

        // start held with new operands while busy must not disturb the running op.
        drive(16'h00FF, 16'h0001, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.a = 16'hAAAA;
        wait_done(cnt);
        check("t3_lat", 32'(cnt), 32'd8);
        check("t3_sum", 32'(bus.sum), 32'h0100);
        check("t3_cout", 32'(bus.c_out), 32'd0);
        tick();
        check("t3_accept_on_done", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done(cnt);
        check("t3b_lat", 32'(cnt), 32'd8);
        check("t3b_sum", 32'(bus.sum), 32'hAAAB);

        // Back-to-back with start held high.
        drive(ba[0], bb[0], bc[0], 1'b0);
        bus.start = 1'b1;
        tick();
        for (int j = 0; j < 3; j++) begin
            if (j < 2) drive(ba[j+1], bb[j+1], bc[j+1], 1'b0);
            else       bus.start = 1'b0;
            wait_done(cnt);
            check("b2b_lat", 32'(cnt), 32'd8);
            check("b2b_sum", 32'(bus.sum), 32'(bs[j]));
            check("b2b_cout", 32'(bus.c_out), 32'(bco[j]));
            if (j < 2) begin
                tick();
                check("b2b_nobubble", 32'(bus.busy), 32'd1);
            end
        end
        tick();

`ifdef PSA_SUB_EN
        run_op("sub_dir", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
`endif

        for (int n = 0; n < 2000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
`ifdef PSA_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            if (rs) begin
                es = ra - rb;
                ec = (ra >= rb);
            end else begin
                full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
                es   = full[15:0];
                ec   = full[16];
            end
            run_op("rand", ra, rb, rc, rs, es, ec);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/prefix_sweep_adder.md
Name: prefix_sweep_adder

Overview:
- Iterative Brent-Kung prefix adder that time-multiplexes the prefix tree.
- The combinational G/P combine cells compute the whole tree in one cycle; this block instead sweeps it one level per clock, up-sweep then down-sweep, reusing one row of combine cells.
- Sits beside the combinational prefix adders as the area-lean, multi-cycle alternative, with a start/done handshake.

Parameters:
- WIDTH, 16, operand width in bits; must be a power of two and at least 4.
- LEVELS, clog2(WIDTH), number of tree levels L; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured when start is accepted
- b  input  WIDTH  operand B, captured when start is accepted
- c_in  input  1  carry-in, captured when start is accepted
- busy  output  1  high from the accept edge until the result edge
- done  output  1  one-cycle pulse when sum/c_out are updated
- sum  output  WIDTH  registered result
- c_out  output  1  registered carry-out

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, sum=0, c_out=0; internal G/P/p arrays cleared.
- States: IDLE -> UP -> DOWN -> SUM -> IDLE.
- Accept edge E0, in IDLE with start=1:
  - latch p[i]=a[i]^b[i] and G[i]=a[i]&b[i], except G[0]=g0|(p0&c_in);
  - P[i]=p[i]; latch c_in; busy=1; go to UP with level k=0.
- UP, one edge per level, k=0..L-1:
  - for every i with (i+1) mod 2^(k+1)==0: (G,P)[i] <= combine((G,P)[i], (G,P)[i-2^k]);
  - after k=L-1, go to DOWN with k=L-2.
- DOWN, one edge per level, k=L-2..0:
  - for every i with (i+1) mod 2^(k+1)==2^k and i>=2^(k+1): (G,P)[i] <= combine((G,P)[i], (G,P)[i-2^k]);
  - after k=0, go to SUM.
- combine(hi,lo): G=Ghi|(Phi&Glo), P=Phi&Plo.
- All updates within one level read pre-edge values (single-level register update).
- SUM edge: sum[0]=p[0]^c_in; sum[i]=p[i]^G[i-1] for i>=1; c_out=G[WIDTH-1]. Then busy=0, done=1 for exactly one cycle, state=IDLE.
- Latency: 2L edges from accept to result (WIDTH=16: 8 edges).
- sum/c_out hold their value until the next SUM edge.
- start while busy: ignored; operands are not re-sampled.
- start high in the cycle done is high: accepted (state is IDLE), giving back-to-back operations with no bubble.
- Reset mid-operation: operation aborted; no done pulse; outputs return to reset values.
- Width rules: all arithmetic is modulo 2^WIDTH; carry-out is reported only via c_out.

Optional Feature:
- Macro: PSA_SUB_EN.
- Defined: adds input port sub (1 bit), captured at accept. When sub=1, b is replaced by ~b and c_in is forced to 1, so sum=a-b and c_out=1 means no borrow.
- Undefined: no sub port; the block adds only.

Decomposition:
- Package psa_pkg holds:
  - the state enum {IDLE, UP, DOWN, SUM};
  - clog2 and the level-mask function that returns active node indices per level and direction.
- One sub-module, gp_combine_cell (inputs G_hi, P_hi, G_lo, P_lo; outputs G, P), instantiated WIDTH times as a generate row.
- Per-level enables gate each cell; the level counter and FSM live in the top module.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1; done pulses exactly 8 edges after accept; busy high for those 8 cycles.
- a=0x1234, b=0x4321, c_in=1 -> sum=0x5556, c_out=0.
- Accept a=0x00FF, b=0x0001; drive start with a=0xAAAA every cycle while busy -> result sum=0x0100 only; a second op starts only on the done cycle.
- Back-to-back: start held high continuously -> done every 8 cycles; each result matches its own captured operands.
- Assert rst at edge 4 of an operation -> busy, done, sum, c_out go to 0 immediately; no done pulse; the next start works normally.
- PSA_SUB_EN defined: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0. Then 2000 random {a,b,c_in,sub} vectors compared against a behavioural +/- model.
